crc_dma_ctrl: RTL and testbench
===============================

// Module: crc_dma_ctrl
// PURPOSE
// Sequences one CRC job from the config registers to completion. It streams the raw data from addr_src
// through the CRC core in read bursts of up to BURST_MAX words, buffers each burst, and copies it to addr_dst.
// It then writes the CRC word after the data and reports veri_result/intr_type back to the config slave.
// It sits between the AXI config slave, the AXI read/write master ports and the CRC core.
// PARAMETERS
// ADDR_WIDTH  32  byte address width
// DATA_WIDTH  32  data width (word = 4 bytes; only 32 supported)
// BURST_MAX   16  max beats per burst, also internal buffer depth (power of 2, <=16)
// TO_CYCLES   1024  handshake watchdog limit (used only with CRC_TIMEOUT_EN)
// PORTS
// clk            in   1   clock
// rst_n          in   1   async active-low reset
// data_received  in   1   config written (sticky level); job starts on its 0->1 edge
// intr_checked   in   1   intr read by software (sticky level); 0->1 edge clears intr
// addr_src       in   32  source byte address, word aligned
// addr_dst       in   32  destination byte address, word aligned
// data_len       in   16  raw data length in bytes
// crc_mode       in   3   0..3 = crc8/crc12/crc16/ccitt; passed through to core
// veri_result    out  2   00 idle/busy, 01 done OK, 10 done with error
// intr_type      out  6   [0]done [1]rd err [2]wr err [3]len zero [4]bad mode/misaligned [5]timeout
// intr           out  1   level interrupt, = |intr_type
// rd_req/rd_ack  out/in  1  read burst request, accepted when both high
// rd_addr        out  32  burst start address
// rd_len         out  4   beats-1
// rd_data        in   32  read beat; always accepted when rd_valid
// rd_valid/rd_last/rd_err  in  1  beat valid, last beat, SLVERR on beat
// wr_req/wr_ack  out/in  1  write burst request
// wr_addr        out  32  write burst start address
// wr_len         out  4   write burst beats-1
// wr_data        out  32  write beat
// wr_strb        out  4   byte enables (partial on final data word)
// wr_valid/wr_last  out  1  beat valid, last beat
// wr_ready       in   1   beat accepted when wr_valid&wr_ready
// wr_done/wr_err in   1   write response pulse; wr_err = SLVERR
// crc_init/crc_en  out  1  core clear pulse; word enable
// crc_din        out  32  word to core
// crc_bvalid     out  4   valid bytes of crc_din, MSB-first
// crc_mode_o     out  3   registered crc_mode
// crc_out        in   16  core result, valid 2 cycles after last crc_en
// BEHAVIOUR
// Reset: all outputs 0, state IDLE, buffer contents undefined.
// FSM: IDLE->CHECK->RD_REQ->RD_DATA->WR_REQ->WR_DATA->WR_RESP->(RD_REQ | CRC_WAIT)->CRC_REQ->CRC_DATA->CRC_RESP->DONE; ERR.
// IDLE: on data_received edge, latch addr/len/mode and pulse crc_init for 1 cycle; clear veri_result to 00.
// CHECK: len==0 -> ERR with [3]; mode>3 or addr[1:0]!=0 -> ERR with [4]; else RD_REQ.
// Words = ceil(len/4); burst beats = min(BURST_MAX, words left). rd_req holds stable until rd_ack.
// RD_DATA: each rd_valid stores the word in buf[idx] and asserts crc_en the same cycle. crc_bvalid=4'hF except the final
// job word: (len%4==0) ? F : MSB-first mask of len%4 bytes. rd_err -> finish burst, then ERR [1].
// rd_last must coincide with the final expected beat; a mismatch -> ERR [1].
// WR_DATA: buf[0..beats-1] sent in order, wr_strb as crc_bvalid, wr_last on final beat; advance only on wr_ready.
// WR_RESP: wait wr_done; wr_err -> ERR [2]. src/dst advance by 4*beats. Remaining words >0 -> RD_REQ, else CRC_WAIT.
// CRC_WAIT: 2 cycles. CRC word = {16'b0, crc_out}, single beat, strb F, at addr_dst_start + words*4.
// DONE/ERR: set intr_type bit(s) ([0] also in DONE) and veri_result 01/10. Hold until intr_checked 0->1 edge,
// then clear intr_type and return to IDLE; veri_result is held until the next job start.
// A data_received edge while not IDLE is ignored. Async reset mid-job aborts immediately; requests drop.
// Word counters are 15 bits; addresses wrap mod 2^32 without error.
// CONFIGURATION
// CRC_TIMEOUT_EN defined: a 16-bit watchdog counts cycles in RD_REQ/RD_DATA/WR_REQ/WR_DATA/WR_RESP/CRC_* with no
// handshake progress. Reaching TO_CYCLES -> ERR with [5]; outstanding requests/valids are dropped.
// Undefined: no watchdog, intr_type[5] tied 0, the controller waits forever.
// TESTING
// len=8, mode=2, src=0x100, dst=0x200 -> 1 rd burst rd_len=1; wr 0x200 x2; CRC write at 0x208; intr_type=01, veri=01.
// len=70 -> bursts 16+2 words; last word crc_bvalid=4'hC; CRC write at dst+72.
// len=0 -> no rd_req; intr_type=6'h08, veri=10; intr_checked edge -> intr_type=0, state IDLE.
// rd_err on beat 3 of 4 -> no wr_req; intr_type=6'h02, veri=10.
// wr_ready held low 5 cycles mid-burst -> wr_data/wr_strb/wr_last stable; completes OK.
// CRC_TIMEOUT_EN, TO_CYCLES=64, rd_ack never -> ERR after 64 cycles, intr_type=6'h20; rst_n low mid-burst -> outputs 0.

Source files
------------

// File: rtl/crc_dma_ctrl.sv
// crc_dma_ctrl: one CRC job - burst-read source through the CRC core, copy to destination, append the CRC word.
// Optional CRC_TIMEOUT_EN adds a handshake watchdog raising intr_type[5].
module crc_dma_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 16,
  parameter int TO_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_received,
  input  logic                  intr_checked,
  input  logic [ADDR_WIDTH-1:0] addr_src,
  input  logic [ADDR_WIDTH-1:0] addr_dst,
  input  logic [15:0]           data_len,
  input  logic [2:0]            crc_mode,
  output logic [1:0]            veri_result,
  output logic [5:0]            intr_type,
  output logic                  intr,
  output logic                  rd_req,
  input  logic                  rd_ack,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [3:0]            rd_len,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  input  logic                  rd_last,
  input  logic                  rd_err,
  output logic                  wr_req,
  input  logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [3:0]            wr_len,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [3:0]            wr_strb,
  output logic                  wr_valid,
  output logic                  wr_last,
  input  logic                  wr_ready,
  input  logic                  wr_done,
  input  logic                  wr_err,
  output logic                  crc_init,
  output logic                  crc_en,
  output logic [DATA_WIDTH-1:0] crc_din,
  output logic [3:0]            crc_bvalid,
  output logic [2:0]            crc_mode_o,
  input  logic [15:0]           crc_out
);
  localparam int IW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  if (DATA_WIDTH != 32 || BURST_MAX > 16 || BURST_MAX < 1 || TO_CYCLES < 2) begin : g_bad_cfg
    $error("crc_dma_ctrl: unsupported parameter set");
  end
  typedef enum logic [3:0] {
    IDLE, CHECK, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_RESP,
    CRC_WAIT, CRC_REQ, CRC_DATA, CRC_RESP, DONE, ERR
  } state_t;
  state_t state, state_n;
  logic dr_q, ic_q, rd_bad, cw;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [15:0] len_q, crc_q;
  logic [2:0] mode_q;
  logic [14:0] words_left;
  logic [4:0] idx, beats;
  logic [5:0] err_c;
  logic [16:0] len_p3;
  logic [3:0] tail;
  logic [31:0] mem [BURST_MAX];
  logic start, ack_intr, last_burst, last_beat, final_word;
  assign start      = data_received & ~dr_q;
  assign ack_intr   = intr_checked & ~ic_q;
  assign len_p3     = {1'b0, len_q} + 17'd3;
  assign beats      = (words_left > 15'(BURST_MAX)) ? 5'(BURST_MAX) : words_left[4:0];
  assign last_burst = words_left == {10'b0, beats};
  assign last_beat  = idx == beats - 5'd1;
  assign final_word = last_burst & last_beat;
  assign tail       = (len_q[1:0] == 2'd0) ? 4'hF : (len_q[1:0] == 2'd1) ? 4'h8 :
                      (len_q[1:0] == 2'd2) ? 4'hC : 4'hE;
`ifdef CRC_TIMEOUT_EN
  logic [15:0] wd;
  logic watch, progress, timeout;
  assign watch    = state inside {RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_RESP, CRC_WAIT, CRC_REQ, CRC_DATA, CRC_RESP};
  assign progress = (rd_req & rd_ack) | crc_en | (wr_req & wr_ack) | (wr_valid & wr_ready) | wr_done;
  assign timeout  = watch & ~progress & (wd >= 16'(TO_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd <= '0;
    else wd <= (state_n != state || progress || !watch) ? 16'd0 : wd + 16'd1;
`endif
  always_comb begin
    state_n = state;
    err_c   = 6'h00;
    case (state)
      IDLE:     if (start) state_n = CHECK;
      CHECK: begin
        state_n = (len_q == 16'd0 || mode_q[2] || src[1:0] != 2'b00 || dst[1:0] != 2'b00) ? ERR : RD_REQ;
        err_c   = (len_q == 16'd0) ? 6'h08 : (state_n == ERR) ? 6'h10 : 6'h00;
      end
      RD_REQ:   if (rd_ack) state_n = RD_DATA;
      RD_DATA:
        if (rd_valid && (last_beat || rd_last)) begin
          state_n = (rd_bad || rd_err || (rd_last != last_beat)) ? ERR : WR_REQ;
          err_c   = (state_n == ERR) ? 6'h02 : 6'h00;
        end
      WR_REQ:   if (wr_ack) state_n = WR_DATA;
      WR_DATA:  if (wr_ready && last_beat) state_n = WR_RESP;
      WR_RESP:
        if (wr_done) begin
          state_n = wr_err ? ERR : last_burst ? CRC_WAIT : RD_REQ;
          err_c   = wr_err ? 6'h04 : 6'h00;
        end
      CRC_WAIT: if (cw) state_n = CRC_REQ;
      CRC_REQ:  if (wr_ack) state_n = CRC_DATA;
      CRC_DATA: if (wr_ready) state_n = CRC_RESP;
      CRC_RESP:
        if (wr_done) begin
          state_n = wr_err ? ERR : DONE;
          err_c   = wr_err ? 6'h04 : 6'h00;
        end
      DONE, ERR: if (ack_intr) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
`ifdef CRC_TIMEOUT_EN
    if (timeout) begin
      state_n = ERR;
      err_c   = 6'h20;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      dr_q        <= 1'b0;
      ic_q        <= 1'b0;
      src         <= '0;
      dst         <= '0;
      len_q       <= '0;
      mode_q      <= '0;
      words_left  <= '0;
      idx         <= '0;
      rd_bad      <= 1'b0;
      cw          <= 1'b0;
      crc_q       <= '0;
      crc_init    <= 1'b0;
      veri_result <= '0;
      intr_type   <= '0;
    end else begin
      state    <= state_n;
      dr_q     <= data_received;
      ic_q     <= intr_checked;
      crc_init <= 1'b0;
      if (state == IDLE && start) begin
        src         <= addr_src;
        dst         <= addr_dst;
        len_q       <= data_len;
        mode_q      <= crc_mode;
        crc_init    <= 1'b1;
        veri_result <= 2'b00;
      end
      if (state == CHECK) words_left <= len_p3[16:2];
      if ((rd_req && rd_ack) || (wr_req && wr_ack)) begin
        idx    <= '0;
        rd_bad <= 1'b0;
      end
      if (crc_en) begin
        idx    <= idx + 5'd1;
        rd_bad <= rd_bad | rd_err;
      end
      if (state == WR_DATA && wr_ready) idx <= idx + 5'd1;
      if (state == WR_RESP && wr_done && !wr_err) begin
        src        <= src + ADDR_WIDTH'({beats, 2'b00});
        dst        <= dst + ADDR_WIDTH'({beats, 2'b00});
        words_left <= words_left - {10'b0, beats};
      end
      if (state == CRC_WAIT) cw <= ~cw;
      if (state == CRC_WAIT && cw) crc_q <= crc_out;
      if (state_n == ERR && state != ERR) begin
        intr_type   <= err_c;
        veri_result <= 2'b10;
      end
      if (state_n == DONE && state != DONE) begin
        intr_type   <= 6'h01;
        veri_result <= 2'b01;
      end
      if ((state == DONE || state == ERR) && ack_intr) intr_type <= '0;
    end
  always_ff @(posedge clk)
    if (crc_en) mem[idx[IW-1:0]] <= rd_data;
  assign intr       = |intr_type;
  assign crc_mode_o = mode_q;
  assign rd_req     = state == RD_REQ;
  assign rd_addr    = rd_req ? src : '0;
  assign rd_len     = rd_req ? 4'(beats - 5'd1) : 4'h0;
  assign crc_en     = (state == RD_DATA) & rd_valid;
  assign crc_din    = crc_en ? rd_data : '0;
  assign crc_bvalid = crc_en ? (final_word ? tail : 4'hF) : 4'h0;
  assign wr_req     = (state == WR_REQ) | (state == CRC_REQ);
  assign wr_addr    = wr_req ? dst : '0;
  assign wr_len     = (state == WR_REQ) ? 4'(beats - 5'd1) : 4'h0;
  assign wr_valid   = (state == WR_DATA) | (state == CRC_DATA);
  assign wr_data    = (state == WR_DATA) ? mem[idx[IW-1:0]] : (state == CRC_DATA) ? {16'h0000, crc_q} : '0;
  assign wr_strb    = (state == WR_DATA) ? (final_word ? tail : 4'hF) : (state == CRC_DATA) ? 4'hF : 4'h0;
  assign wr_last    = ((state == WR_DATA) & last_beat) | (state == CRC_DATA);
endmodule

// File: tb/tb_crc_dma_ctrl.sv
// tb_crc_dma_ctrl: directed self-checking bench for crc_dma_ctrl with a hand-driven read/write slave.
module tb_crc_dma_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic data_received = 1'b0, intr_checked = 1'b0;
  logic [31:0] addr_src = '0, addr_dst = '0;
  logic [15:0] data_len = '0;
  logic [2:0] crc_mode = '0;
  logic [1:0] veri_result;
  logic [5:0] intr_type;
  logic intr, rd_req, rd_ack = 1'b0, rd_valid = 1'b0, rd_last = 1'b0, rd_err = 1'b0;
  logic [31:0] rd_addr, rd_data = '0, wr_addr, wr_data, crc_din;
  logic [3:0] rd_len, wr_len, wr_strb, crc_bvalid;
  logic wr_req, wr_ack = 1'b0, wr_valid, wr_last, wr_ready = 1'b0, wr_done = 1'b0, wr_err = 1'b0;
  logic crc_init, crc_en;
  logic [2:0] crc_mode_o;
  logic [15:0] crc_out = 16'hBEEF;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  crc_dma_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_MAX(16), .TO_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .data_received(data_received), .intr_checked(intr_checked),
    .addr_src(addr_src), .addr_dst(addr_dst), .data_len(data_len), .crc_mode(crc_mode),
    .veri_result(veri_result), .intr_type(intr_type), .intr(intr),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_addr(rd_addr), .rd_len(rd_len), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_err(rd_err),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
    .wr_done(wr_done), .wr_err(wr_err), .crc_init(crc_init), .crc_en(crc_en), .crc_din(crc_din),
    .crc_bvalid(crc_bvalid), .crc_mode_o(crc_mode_o), .crc_out(crc_out)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l, input logic [2:0] m);
    data_received = 1'b0;
    addr_src = s; addr_dst = d; data_len = l; crc_mode = m;
    @(negedge clk); @(negedge clk);
    data_received = 1'b1;
    @(negedge clk);
    chk("crc_init pulse", {31'b0, crc_init}, 1);
    chk("veri cleared", {30'b0, veri_result}, 0);
    chk("crc_mode_o", {29'b0, crc_mode_o}, {29'b0, m});
  endtask
  task automatic read_burst(input logic [31:0] a, input logic [3:0] l, input int nb, input logic [31:0] d0,
                            input logic [3:0] last_bv, input int eb);
    int n = 0;
    while (!rd_req && n < 50) begin @(negedge clk); n++; end
    chk("rd_req seen", {31'b0, rd_req}, 1);
    chk("rd_addr", rd_addr, a);
    chk("rd_len", {28'b0, rd_len}, {28'b0, l});
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    for (int i = 0; i < nb; i++) begin
      rd_valid = 1'b1; rd_data = d0 + 32'(i); rd_last = (i == nb - 1); rd_err = (i == eb);
      #1;
      chk("crc_en", {31'b0, crc_en}, 1);
      chk("crc_din", crc_din, d0 + 32'(i));
      chk("crc_bvalid", {28'b0, crc_bvalid}, {28'b0, (i == nb - 1) ? last_bv : 4'hF});
      @(negedge clk);
    end
    rd_valid = 1'b0; rd_last = 1'b0; rd_err = 1'b0;
  endtask
  task automatic write_burst(input logic [31:0] a, input logic [3:0] l, input int nb, input logic [31:0] d0,
                             input logic [3:0] last_strb, input int stall, input logic e);
    int n = 0;
    while (!wr_req && n < 50) begin @(negedge clk); n++; end
    chk("wr_req seen", {31'b0, wr_req}, 1);
    chk("wr_addr", wr_addr, a);
    chk("wr_len", {28'b0, wr_len}, {28'b0, l});
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < nb; i++) begin
      if (i == stall) begin
        wr_ready = 1'b0;
        repeat (5) begin
          #1;
          chk("stall wr_valid", {31'b0, wr_valid}, 1);
          chk("stall wr_data", wr_data, d0 + 32'(i));
          chk("stall wr_strb", {28'b0, wr_strb}, 32'hF);
          chk("stall wr_last", {31'b0, wr_last}, {31'b0, i == nb - 1});
          @(negedge clk);
        end
        wr_ready = 1'b1;
      end
      #1;
      chk("wr_valid", {31'b0, wr_valid}, 1);
      chk("wr_data", wr_data, d0 + 32'(i));
      chk("wr_strb", {28'b0, wr_strb}, {28'b0, (i == nb - 1) ? last_strb : 4'hF});
      chk("wr_last", {31'b0, wr_last}, {31'b0, i == nb - 1});
      @(negedge clk);
    end
    wr_ready = 1'b0;
    @(negedge clk);
    wr_done = 1'b1; wr_err = e;
    @(negedge clk);
    wr_done = 1'b0; wr_err = 1'b0;
  endtask
  task automatic finish_job(input logic [5:0] it, input logic [1:0] vr);
    int n = 0;
    logic saw_req = 1'b0;
    while (!intr && n < 50) begin
      saw_req |= rd_req | wr_req;
      @(negedge clk); n++;
    end
    chk("intr raised", {31'b0, intr}, 1);
    chk("no request while finishing", {31'b0, saw_req}, 0);
    chk("intr_type", {26'b0, intr_type}, {26'b0, it});
    chk("veri_result", {30'b0, veri_result}, {30'b0, vr});
    intr_checked = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("intr_type cleared", {26'b0, intr_type}, 0);
    chk("intr cleared", {31'b0, intr}, 0);
    chk("veri held", {30'b0, veri_result}, {30'b0, vr});
    intr_checked = 1'b0;
  endtask
  initial begin
    #1;
    chk("reset rd_req", {31'b0, rd_req}, 0);
    chk("reset wr_valid", {31'b0, wr_valid}, 0);
    chk("reset intr_type", {26'b0, intr_type}, 0);
    chk("reset veri", {30'b0, veri_result}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(32'h100, 32'h200, 16'd8, 3'd2);
    read_burst(32'h100, 4'd1, 2, 32'hA000_0000, 4'hF, -1);
    write_burst(32'h200, 4'd1, 2, 32'hA000_0000, 4'hF, -1, 1'b0);
    write_burst(32'h208, 4'd0, 1, 32'h0000_BEEF, 4'hF, -1, 1'b0);
    finish_job(6'h01, 2'b01);
    start_job(32'h1000, 32'h2000, 16'd70, 3'd3);
    read_burst(32'h1000, 4'd15, 16, 32'h100, 4'hF, -1);
    write_burst(32'h2000, 4'd15, 16, 32'h100, 4'hF, 5, 1'b0);
    read_burst(32'h1040, 4'd1, 2, 32'h110, 4'hC, -1);
    write_burst(32'h2040, 4'd1, 2, 32'h110, 4'hC, -1, 1'b0);
    write_burst(32'h2048, 4'd0, 1, 32'h0000_BEEF, 4'hF, -1, 1'b0);
    finish_job(6'h01, 2'b01);
    start_job(32'h100, 32'h200, 16'd0, 3'd0);
    finish_job(6'h08, 2'b10);
    start_job(32'h300, 32'h400, 16'd16, 3'd1);
    read_burst(32'h300, 4'd3, 4, 32'h55, 4'hF, 2);
    finish_job(6'h02, 2'b10);
    start_job(32'h300, 32'h400, 16'd16, 3'd5);
    finish_job(6'h10, 2'b10);
    start_job(32'h302, 32'h400, 16'd16, 3'd0);
    finish_job(6'h10, 2'b10);
    start_job(32'h600, 32'h700, 16'd3, 3'd1);
    read_burst(32'h600, 4'd0, 1, 32'h77, 4'hE, -1);
    write_burst(32'h700, 4'd0, 1, 32'h77, 4'hE, -1, 1'b1);
    finish_job(6'h04, 2'b10);
    start_job(32'h500, 32'h800, 16'd16, 3'd2);
    begin
      int n = 0;
      while (!rd_req && n < 50) begin @(negedge clk); n++; end
      chk("rst test rd_req", {31'b0, rd_req}, 1);
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0; rd_valid = 1'b1; rd_data = 32'h1234;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst crc_en", {31'b0, crc_en}, 0);
      chk("rst rd_req", {31'b0, rd_req}, 0);
      chk("rst wr_req", {31'b0, wr_req}, 0);
      chk("rst crc_mode_o", {29'b0, crc_mode_o}, 0);
      chk("rst veri", {30'b0, veri_result}, 0);
      rd_valid = 1'b0; data_received = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
`ifdef CRC_TIMEOUT_EN
    start_job(32'h100, 32'h200, 16'd8, 3'd0);
    begin
      int n = 0;
      while (!rd_req && n < 50) begin @(negedge clk); n++; end
      chk("to rd_req", {31'b0, rd_req}, 1);
      n = 0;
      while (!intr && n < 200) begin @(negedge clk); n++; end
      chk("to cycles", 32'(n), 64);
      chk("to intr_type", {26'b0, intr_type}, 32'h20);
      chk("to rd_req dropped", {31'b0, rd_req}, 0);
      chk("to veri", {30'b0, veri_result}, 2);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
